dft_pair_collector: RTL
=======================

# dft_pair_collector

Receive-side endpoint for the two DFT result streams (real and imaginary) emitted by the DFT compute block. Accepts each stream independently through its own busy/vld port and buffers it in a small per-stream FIFO. Pairs the streams into one complex-bin output stream with a bin index, a last-of-frame marker and a frame counter. Sits directly downstream of the DFT core and feeds the post-processing or readout stage.

## Interface
- N_POINTS, 16: bins per DFT frame; power of two, ≥2.
- FIFO_DEPTH, 4: entries per input FIFO; power of two, ≥2.
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_dft_real_vld  in  1  real-part word valid.
- i_dft_real_busy  out  1  collector cannot accept a real word.
- i_dft_real_data_man / _exp / _sign  in  23 / 8 / 1  real part, IEEE-754 single fields.
- i_dft_imag_vld  in  1  imag-part word valid.
- i_dft_imag_busy  out  1  collector cannot accept an imag word.
- i_dft_imag_data_man / _exp / _sign  in  23 / 8 / 1  imag part fields.
- o_bin_vld  out  1  paired bin valid.
- o_bin_busy  in  1  downstream cannot accept.
- o_bin_real  out  32  packed {sign, exp, man} real part.
- o_bin_imag  out  32  packed {sign, exp, man} imag part.
- o_bin_index  out  log2(N_POINTS)  bin number within frame.
- o_bin_last  out  1  high when o_bin_index == N_POINTS-1.
- o_frame_cnt  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- Handshake on every port: a word transfers on a rising edge where vld=1 and busy=0. The producer holds data and vld stable while busy=1. vld is never gated by busy.
- Each input stream has its own FIFO of FIFO_DEPTH entries. On transfer, the 32-bit word {sign, exp, man} is pushed.
- i_dft_*_busy = (FIFO count == FIFO_DEPTH).
  - Driven from registered count only; there is no combinational path from o_bin_busy.
  - When full, a same-cycle pop does not permit a push; busy stays high for that cycle.
- The output stage is a single register holding real, imag, index and last.
  - Load condition: both FIFOs non-empty AND (o_bin_vld=0 OR output transfer this cycle).
  - Load pops both FIFOs simultaneously.
  - The output transfer and the reload may occur on the same edge, giving full throughput of 1 bin/cycle.
- Bin index counter:
  - Increments on each load.
  - Wraps from N_POINTS-1 to 0.
  - The loaded index is the counter value before the increment.
- o_frame_cnt increments on the output transfer of a bin with o_bin_last=1.
- Skew between streams is absorbed up to FIFO_DEPTH words. Beyond that, the leading stream is backpressured via its busy. There is no data loss and no deadlock.
- Data is passed through unmodified. NaN, Inf and denormal values are not inspected.

## Timing
- Reset values:
  - i_dft_real_busy=0, i_dft_imag_busy=0, o_bin_vld=0.
  - o_bin_real=0, o_bin_imag=0, o_bin_index=0, o_bin_last=0, o_frame_cnt=0.
  - FIFOs empty; bin index counter=0.
- Latency: with both FIFOs and the output register empty, a real and an imag word accepted on edge k give o_bin_vld=1 after edge k+1.
- If the two words of a pair arrive on different edges, o_bin_vld rises one edge after the later of the two.
- While o_bin_busy=1 and o_bin_vld=1, every output stays stable.
- Asserting reset mid-frame discards FIFO contents and any held bin. The next accepted pair is index 0.

## Structure
- Shared package dft_pkg holds:
  - FP_MAN_W=23, FP_EXP_W=8, float32 packed typedef {sign, exp, man}.
  - The pack helper, and the index width helper log2(N_POINTS).
- Sub-module dft_stream_fifo holds one synchronous FIFO: 32-bit data, parameter DEPTH, push/pop, full/empty, count. It is instantiated once for real and once for imag.
- Top level holds the pairing/load logic, bin index counter and frame counter.

## Test plan
- Lockstep stream: 16 pairs, both vld every cycle, o_bin_busy=0.
  - Required: bins 0..15 back-to-back.
  - o_bin_last only on index 15; o_frame_cnt 0→1; first o_bin_vld one edge after the first acceptance.
- Skew: send 4 real words (0x3F800000 = 1.0) with imag idle.
  - Required: i_dft_real_busy=1 after the 4th; o_bin_vld stays 0.
  - Then send 4 imag words (0xBF800000): 4 bins, each real=0x3F800000, imag=0xBF800000, indices 0..3.
- Backpressure: hold o_bin_busy=1 for 10 cycles with both streams active.
  - Required: output stable; both busy go high once 4 words are buffered per FIFO.
  - On release, no word is lost or duplicated; indices are continuous.
- Same-edge transfer and reload: o_bin_busy toggling 1/0 every cycle.
  - Required: every transfer carries a strictly incrementing index; throughput is 1 bin per 2 cycles.
- Reset mid-frame: assert i_rst asynchronously after bin 7.
  - Required: all outputs reset immediately; next frame starts at index 0; o_frame_cnt=0.
- Frame counter wrap: preload via 65536 frames (or a force in simulation).
  - Required: o_frame_cnt goes 0xFFFF→0x0000 on the last-bin transfer.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types and helpers for the DFT result path: float32 field layout,
// packing helper and bin-index width helper.
package dft_pkg;

    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_W     = 1 + FP_EXP_W + FP_MAN_W;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } float32_t;

    function automatic float32_t fp_pack(input logic                sign,
                                         input logic [FP_EXP_W-1:0] exp,
                                         input logic [FP_MAN_W-1:0] man);
        float32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.man  = man;
        return f;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n_points);
        return $clog2(n_points);
    endfunction

endpackage

// File: rtl/dft_stream_fifo.sv
// Single-clock FIFO for one DFT result stream. Pushes while full and pops
// while empty are ignored, so callers may gate loosely.
module dft_stream_fifo
    import dft_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [FP_W-1:0] data_i,
    input  logic            pop_i,
    output logic [FP_W-1:0] data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [FP_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap on overflow
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dft_pair_collector.sv
// Buffers the real and imaginary DFT streams independently and pairs them
// into one complex-bin stream with bin index, last marker and frame count.
module dft_pair_collector
    import dft_pkg::*;
#(
    parameter int unsigned N_POINTS   = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IdxW      = idx_width(N_POINTS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_dft_real_vld,
    output logic                i_dft_real_busy,
    input  logic [FP_MAN_W-1:0] i_dft_real_data_man,
    input  logic [FP_EXP_W-1:0] i_dft_real_data_exp,
    input  logic                i_dft_real_data_sign,
    input  logic                i_dft_imag_vld,
    output logic                i_dft_imag_busy,
    input  logic [FP_MAN_W-1:0] i_dft_imag_data_man,
    input  logic [FP_EXP_W-1:0] i_dft_imag_data_exp,
    input  logic                i_dft_imag_data_sign,
    output logic                o_bin_vld,
    input  logic                o_bin_busy,
    output logic [FP_W-1:0]     o_bin_real,
    output logic [FP_W-1:0]     o_bin_imag,
    output logic [IdxW-1:0]     o_bin_index,
    output logic                o_bin_last,
    output logic [15:0]         o_frame_cnt
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_POINTS - 1);

    logic [FP_W-1:0] real_word, imag_word;
    logic [FP_W-1:0] real_head, imag_head;
    logic            real_full, imag_full;
    logic            real_empty, imag_empty;
    logic [CntW-1:0] real_count, imag_count;
    logic            real_push, imag_push;
    logic            load, out_xfer;

    logic            bin_vld_q, bin_vld_d;
    logic [FP_W-1:0] bin_real_q, bin_real_d;
    logic [FP_W-1:0] bin_imag_q, bin_imag_d;
    logic [IdxW-1:0] bin_idx_q, bin_idx_d;
    logic            bin_last_q, bin_last_d;
    logic [IdxW-1:0] idx_cnt_q, idx_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    assign real_word = fp_pack(i_dft_real_data_sign, i_dft_real_data_exp, i_dft_real_data_man);
    assign imag_word = fp_pack(i_dft_imag_data_sign, i_dft_imag_data_exp, i_dft_imag_data_man);

    // Busy depends only on registered occupancy; a same-cycle pop never frees a slot early
    assign i_dft_real_busy = (real_count == CntW'(FIFO_DEPTH));
    assign i_dft_imag_busy = (imag_count == CntW'(FIFO_DEPTH));
    assign real_push       = i_dft_real_vld & ~real_full;
    assign imag_push       = i_dft_imag_vld & ~imag_full;

    assign out_xfer = bin_vld_q & ~o_bin_busy;
    assign load     = ~real_empty & ~imag_empty & (~bin_vld_q | out_xfer);

    dft_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_real_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (real_push),
        .data_i  (real_word),
        .pop_i   (load),
        .data_o  (real_head),
        .full_o  (real_full),
        .empty_o (real_empty),
        .count_o (real_count)
    );

    dft_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_imag_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (imag_push),
        .data_i  (imag_word),
        .pop_i   (load),
        .data_o  (imag_head),
        .full_o  (imag_full),
        .empty_o (imag_empty),
        .count_o (imag_count)
    );

    always_comb begin
        bin_vld_d   = bin_vld_q;
        bin_real_d  = bin_real_q;
        bin_imag_d  = bin_imag_q;
        bin_idx_d   = bin_idx_q;
        bin_last_d  = bin_last_q;
        idx_cnt_d   = idx_cnt_q;
        frame_cnt_d = frame_cnt_q;

        if (load) begin
            bin_vld_d  = 1'b1;
            bin_real_d = real_head;
            bin_imag_d = imag_head;
            bin_idx_d  = idx_cnt_q;
            bin_last_d = (idx_cnt_q == LastIdx);
            idx_cnt_d  = (idx_cnt_q == LastIdx) ? '0 : idx_cnt_q + IdxW'(1);
        end else if (out_xfer) begin
            bin_vld_d = 1'b0;
        end

        if (out_xfer && bin_last_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin_vld_q   <= 1'b0;
            bin_real_q  <= '0;
            bin_imag_q  <= '0;
            bin_idx_q   <= '0;
            bin_last_q  <= 1'b0;
            idx_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            bin_vld_q   <= bin_vld_d;
            bin_real_q  <= bin_real_d;
            bin_imag_q  <= bin_imag_d;
            bin_idx_q   <= bin_idx_d;
            bin_last_q  <= bin_last_d;
            idx_cnt_q   <= idx_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_bin_vld   = bin_vld_q;
    assign o_bin_real  = bin_real_q;
    assign o_bin_imag  = bin_imag_q;
    assign o_bin_index = bin_idx_q;
    assign o_bin_last  = bin_last_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
